// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the memory scheduler: FSM states, owner
// encodings and the DDR data width.
package mem_sched_pkg;

    localparam int DATA_W = 512;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] GID_NONE = 2'd0;
    localparam logic [1:0] GID_IC   = 2'd1;
    localparam logic [1:0] GID_DC   = 2'd2;
    localparam logic [1:0] GID_PTW  = 2'd3;

    // Bit positions inside the one-hot grant vector.
    localparam int G_IC  = 0;
    localparam int G_DC  = 1;
    localparam int G_PTW = 2;

endpackage

// File: rtl/mem_sched_pick.sv
// Combinational arbiter: ptw always wins; ic and dc alternate on ties using
// the last-grant bit. A flushing icache is not eligible.
module mem_sched_pick
    import mem_sched_pkg::*;
(
    input  logic       ic_valid,
    input  logic       dc_valid,
    input  logic       ptw_valid,
    input  logic       last_dc,
    input  logic       ic_flush,
    output logic [2:0] grant
);

    logic ic_ok;

    always_comb begin
        ic_ok = ic_valid && !ic_flush;
        grant = 3'b000;
        if (ptw_valid) begin
            grant[G_PTW] = 1'b1;
        end else if (ic_ok && dc_valid) begin
            if (last_dc) grant[G_IC] = 1'b1;
            else         grant[G_DC] = 1'b1;
        end else if (ic_ok) begin
            grant[G_IC] = 1'b1;
        end else if (dc_valid) begin
            grant[G_DC] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_sched.sv
// Single-outstanding DDR scheduler for icache, dcache and page-table walker.
// valid/ready: a request is taken only in the cycle its ready pulses.
module mem_sched
    import mem_sched_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int ADDR_W  = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ic_req_valid,
    input  logic              dc_req_valid,
    input  logic              ptw_req_valid,
    output logic              ic_req_ready,
    output logic              dc_req_ready,
    output logic              ptw_req_ready,
    input  logic [ADDR_W-1:0] ic_req_index,
    input  logic [ADDR_W-1:0] dc_req_index,
    input  logic [ADDR_W-1:0] ptw_req_index,
    input  logic              dc_req_write,
    input  logic [DATA_W-1:0] dc_req_wdata,
    input  logic [DATA_W-1:0] dc_req_wmask,
    output logic              ic_resp_valid,
    output logic              dc_resp_valid,
    output logic              ptw_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,
    output logic [DATA_W-1:0] dc_resp_data,
    output logic [DATA_W-1:0] ptw_resp_data,
    input  logic              ic_flush,
    output logic              ddr_chip_enable,
    output logic              ddr_write_enable,
    output logic              ddr_burst_mode,
    output logic [ADDR_W-1:0] ddr_index,
    output logic [DATA_W-1:0] ddr_write_data,
    output logic [DATA_W-1:0] ddr_write_mask,
    input  logic [DATA_W-1:0] ddr_read_data,
    input  logic              ddr_operation_done,
    input  logic              ddr_ready,
    output logic              timeout_err,
    output logic [1:0]        grant_id,
    output state_t            fsm_state
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [2:0]        grant;
    logic              accept, busy_tmo, ic_mute;
    logic              last_dc, write_q, flushed;
    logic [1:0]        owner;
    logic [ADDR_W-1:0] index_q;
    logic [DATA_W-1:0] wdata_q, wmask_q, data_q;
    logic [DATA_W-1:0] ic_hold, dc_hold, ptw_hold;
    logic [CNT_W-1:0]  cnt;

    mem_sched_pick u_pick (
        .ic_valid  (ic_req_valid),
        .dc_valid  (dc_req_valid),
        .ptw_valid (ptw_req_valid),
        .last_dc   (last_dc),
        .ic_flush  (ic_flush),
        .grant     (grant)
    );

    assign accept   = (state == S_IDLE) && ddr_ready && !reset && (grant != 3'b000);
    assign busy_tmo = (state == S_BUSY) && !ddr_operation_done && (cnt == CNT_LIM);
    // A flush seen at any point after the icache owns the DDR kills its response.
    assign ic_mute  = (owner == GID_IC) && (flushed || ic_flush);

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_BUSY;
            S_BUSY:  if (ddr_operation_done || busy_tmo) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ic_req_ready     = accept && grant[G_IC];
        dc_req_ready     = accept && grant[G_DC];
        ptw_req_ready    = accept && grant[G_PTW];
        ddr_chip_enable  = 1'b0;
        ddr_write_enable = 1'b0;
        ddr_burst_mode   = 1'b0;
        ddr_index        = '0;
        ddr_write_data   = '0;
        ddr_write_mask   = '0;
        if (state == S_BUSY) begin
            ddr_chip_enable  = 1'b1;
            ddr_write_enable = (owner == GID_DC) && write_q;
            ddr_burst_mode   = (owner == GID_IC);
            ddr_index        = index_q;
            ddr_write_data   = wdata_q;
            ddr_write_mask   = wmask_q;
        end
        ic_resp_valid  = (state == S_RESP) && (owner == GID_IC) && !ic_mute;
        dc_resp_valid  = (state == S_RESP) && (owner == GID_DC);
        ptw_resp_valid = (state == S_RESP) && (owner == GID_PTW);
        ic_resp_data   = ic_resp_valid  ? data_q : ic_hold;
        dc_resp_data   = dc_resp_valid  ? data_q : dc_hold;
        ptw_resp_data  = ptw_resp_valid ? data_q : ptw_hold;
        grant_id       = (state == S_IDLE) ? GID_NONE : owner;
        fsm_state      = state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner       <= GID_NONE;
            index_q     <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            data_q      <= '0;
            last_dc     <= 1'b1;
            cnt         <= '0;
            flushed     <= 1'b0;
            timeout_err <= 1'b0;
            ic_hold     <= '0;
            dc_hold     <= '0;
            ptw_hold    <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    owner   <= grant[G_PTW] ? GID_PTW : (grant[G_DC] ? GID_DC : GID_IC);
                    index_q <= grant[G_PTW] ? ptw_req_index :
                               (grant[G_DC] ? dc_req_index : ic_req_index);
                    write_q <= grant[G_DC] && dc_req_write;
                    wdata_q <= grant[G_DC] ? dc_req_wdata : '0;
                    wmask_q <= grant[G_DC] ? dc_req_wmask : '0;
                    cnt     <= '0;
                    flushed <= 1'b0;
                    if (grant[G_IC] || grant[G_DC]) last_dc <= grant[G_DC];
                end
                S_BUSY: begin
                    if (owner == GID_IC && ic_flush) flushed <= 1'b1;
                    if (ddr_operation_done) begin
                        data_q <= ddr_read_data;
                    end else if (busy_tmo) begin
                        data_q      <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (ic_resp_valid)  ic_hold  <= data_q;
                    if (dc_resp_valid)  dc_hold  <= data_q;
                    if (ptw_resp_valid) ptw_hold <= data_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_sched.md
MEM_SCHED -- requirements
Module: mem_sched

Interface
REQ-001 SHALL have parameter: TIMEOUT, 1024, max cycles in BUSY before the transaction is aborted.
REQ-002 SHALL have parameter: ADDR_W, 64, request index width.
REQ-003 SHALL have port: clock  input  1  single rising-edge clock.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports: ic_req_valid, dc_req_valid, ptw_req_valid  input  1  request present.
REQ-006 SHALL have ports: ic_req_ready, dc_req_ready, ptw_req_ready  output  1  one-cycle accept pulse.
REQ-007 SHALL have ports: ic_req_index, dc_req_index, ptw_req_index  input  ADDR_W  target index.
REQ-008 SHALL have ports: dc_req_write  input  1; dc_req_wdata, dc_req_wmask  input  512 (ic, ptw read-only).
REQ-009 SHALL have ports: ic_resp_valid, dc_resp_valid, ptw_resp_valid  output  1 and ic/dc/ptw_resp_data  output  512.
REQ-010 SHALL have port: ic_flush  input  1  discard the in-flight icache result.
REQ-011 SHALL have ports: ddr_chip_enable, ddr_write_enable, ddr_burst_mode  output  1; ddr_index  output  64; ddr_write_data, ddr_write_mask  output  512.
REQ-012 SHALL have ports: ddr_read_data  input  512; ddr_operation_done, ddr_ready  input  1.
REQ-013 SHALL have ports: timeout_err  output  1  sticky abort flag; grant_id  output  2  owner (0 none, 1 ic, 2 dc, 3 ptw).

Function
REQ-014 SHALL implement FSM with states IDLE, BUSY, RESP.
REQ-015 In IDLE with ddr_ready=1 and any req_valid: pick a winner, pulse its req_ready that cycle, latch index/write/wdata/wmask/owner, go BUSY.
REQ-016 Arbitration SHALL be: ptw fixed highest priority; ic vs dc round-robin via a last-grant bit, updated on each ic or dc accept.
REQ-017 In BUSY: ddr_chip_enable=1, ddr_* driven from latched registers only, held stable until ddr_operation_done.
REQ-018 ddr_burst_mode=1 only for ic owner; ddr_write_enable=latched dc_req_write for dc, 0 otherwise.
REQ-019 On ddr_operation_done in BUSY: capture ddr_read_data into the owner's resp_data, go RESP.
REQ-020 In RESP: pulse owner's resp_valid exactly one cycle, go IDLE; next accept earliest in the following cycle.
REQ-021 Latency: accept at cycle N -> chip_enable from N+1; done at cycle M -> resp_valid at M+1.
REQ-022 resp_data SHALL hold its value until that port's next response; write responses return ddr_read_data as received.
REQ-023 Outside BUSY all ddr_* outputs SHALL be 0; grant_id=0 in IDLE.
REQ-024 ic_flush while owner=ic in BUSY or RESP: DDR access completes, ic_resp_valid suppressed.
REQ-025 ic_flush in IDLE: ic not eligible that cycle.
REQ-026 BUSY cycle counter: reaching TIMEOUT without done -> go RESP with resp_data=0, set timeout_err.
REQ-027 Done in the same cycle as the timeout limit: done wins, no error.
REQ-028 timeout_err SHALL be cleared only by reset.

Reset
REQ-029 reset SHALL force IDLE, all outputs 0, last-grant bit = dc (ic wins first tie), counter 0, timeout_err 0.
REQ-030 reset mid-transaction SHALL drop it with no resp_valid; any later ddr_operation_done in IDLE SHALL be ignored.

Structure
REQ-031 Package mem_sched_pkg SHALL hold the state enum, grant_id encodings and the DDR data width constant (512).
REQ-032 Arbitration SHALL be a combinational sub-module mem_sched_pick (valids, last-grant, flush -> one-hot grant).

Verification
REQ-033 dc read at index 0x40, done after 3 cycles -> chip_enable for 3 cycles, dc_resp_valid 1 cycle after done, data matches.
REQ-034 ic, dc, ptw valid together -> grant order ptw, ic, dc; repeat with ic+dc -> alternates ic, dc.
REQ-035 dc write with mask 0xFF -> ddr_write_enable=1, burst=0, mask/data stable through BUSY.
REQ-036 ic read plus ic_flush during BUSY -> DDR completes, no ic_resp_valid, next request accepted normally.
REQ-037 TIMEOUT=16, done never asserted -> after 16 BUSY cycles resp_valid with data 0, timeout_err=1 until reset.
REQ-038 reset in BUSY, then done pulse -> no resp_valid, outputs 0, fresh request accepted.
